// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, opcode classes, sequencer states and reset vector.
package rv32i_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0100_0000;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE,
    OC_OP_IMM, OC_OP, OC_FENCE, OC_SYSTEM, OC_ILLEGAL
  } opclass_e;

  // Map a raw opcode field onto its instruction class.
  function automatic opclass_e classify(input logic [OPC_W-1:0] opc);
    opclass_e oc;
    case (opc)
      OPC_LUI:    oc = OC_LUI;
      OPC_AUIPC:  oc = OC_AUIPC;
      OPC_JAL:    oc = OC_JAL;
      OPC_JALR:   oc = OC_JALR;
      OPC_BRANCH: oc = OC_BRANCH;
      OPC_LOAD:   oc = OC_LOAD;
      OPC_STORE:  oc = OC_STORE;
      OPC_OP_IMM: oc = OC_OP_IMM;
      OPC_OP:     oc = OC_OP;
      OPC_FENCE:  oc = OC_FENCE;
      OPC_SYSTEM: oc = OC_SYSTEM;
      default:    oc = OC_ILLEGAL;
    endcase
    return oc;
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection by instruction class, plus target alignment check.
module next_pc_gen
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  input  opclass_e        opclass,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic            unused_alu_lsb;

  assign seq_pc         = pc + XLEN'(4);
  assign unused_alu_lsb = alu_result[0];

  always_comb begin
    next_pc = seq_pc;
    case (opclass)
      OC_BRANCH: if (branch_taken) next_pc = pc + imm;
      OC_JAL:    next_pc = pc + imm;
      OC_JALR:   next_pc = {alu_result[XLEN-1:1], 1'b0};
      default:   next_pc = seq_pc;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing and PC update.
module pc_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_req,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] ir,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_write,
  output logic            halted,
  output logic            trap
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, ir_q, target;
  logic            run_q, fetch_wait_q;
  logic            ir_load, pc_commit, misaligned;
  opclass_e        opclass;

  assign opclass = classify(ir_q[OPC_W-1:0]);
  assign ir      = ir_q;
  assign pc      = pc_q;
  assign next_pc = pc_write ? target : pc_q;

  next_pc_gen u_next_pc_gen (
    .pc           (pc_q),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .opclass      (opclass),
    .next_pc      (target),
    .misaligned   (misaligned)
  );

  // run_q delays the first fetch one cycle past reset release; fetch_wait_q pins an open fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_VECTOR;
      ir_q         <= '0;
      run_q        <= 1'b0;
      fetch_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      fetch_wait_q <= imem_req && !imem_ready;
      if (ir_load)  ir_q <= instr;
      if (pc_write) pc_q <= target;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_write  = 1'b0;
    halted    = 1'b0;
    trap      = 1'b0;
    ir_load   = 1'b0;
    pc_commit = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          // A fetch already on the bus is never withdrawn for a late halt request.
          if (halt_req && !fetch_wait_q) begin
            state_d = S_HALT;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              ir_load = 1'b1;
              state_d = S_DECODE;
            end
          end
        end
      end
      S_DECODE: state_d = (opclass == OC_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (opclass)
          OC_BRANCH, OC_FENCE: begin
            pc_commit = 1'b1;
            state_d   = S_FETCH;
          end
          OC_SYSTEM: begin
            if (ir_q[14:12] == 3'b000) begin
              pc_commit = 1'b1;
              state_d   = S_HALT;
            end else begin
              state_d = S_WB;
            end
          end
          OC_LOAD, OC_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opclass == OC_STORE);
        if (dmem_ready) begin
          if (opclass == OC_STORE) begin
            pc_commit = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_commit = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase

    if (pc_commit) begin
      if (misaligned) state_d  = S_TRAP;
      else            pc_write = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: an instruction-level model expands each op into a cycle trace.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst, halt_req, imem_ready, dmem_ready, branch_taken;
  logic [31:0] instr, imm, alu_result;
  logic        imem_req, dmem_req, dmem_we, rf_we, pc_write, halted, trap;
  logic [31:0] ir, pc, next_pc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .ir           (ir),
    .imm          (imm),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .rf_we        (rf_we),
    .pc           (pc),
    .next_pc      (next_pc),
    .pc_write     (pc_write),
    .halted       (halted),
    .trap         (trap)
  );

  typedef struct {
    logic chk; int tag;
    logic rst, halt_req, imem_ready, dmem_ready, taken;
    logic [31:0] instr, imm, alu;
    logic imem_req, dmem_req, dmem_we, rf_we, pc_write, halted, trap;
    logic [31:0] pc, next_pc, ir;
  } cyc_t;

  typedef struct {
    logic [31:0] word, imm, alu;
    logic taken;
    int iwait, dwait, halt;
    logic abort;
    int tag;
  } op_t;

  cyc_t        q[$];
  op_t         cur;
  logic [31:0] m_pc, m_ir;
  logic        m_trap, m_in_halt;
  logic [31:0] lit_npc [1:10];
  logic        lit_pw  [1:10];
  int          checks = 0;
  int          failures = 0;

  function automatic cyc_t base();
    cyc_t c;
    c.chk = 1'b1; c.tag = 0;
    c.rst = 1'b1; c.halt_req = 1'b0; c.imem_ready = 1'b0; c.dmem_ready = 1'b0;
    c.taken = cur.taken; c.instr = cur.word; c.imm = cur.imm; c.alu = cur.alu;
    c.imem_req = 1'b0; c.dmem_req = 1'b0; c.dmem_we = 1'b0; c.rf_we = 1'b0;
    c.pc_write = 1'b0; c.halted = 1'b0; c.trap = m_trap;
    c.pc = m_pc; c.next_pc = m_pc; c.ir = m_ir;
    return c;
  endfunction

  function automatic void commit(cyc_t c, logic [31:0] tgt);
    c.tag = cur.tag;
    if (tgt[1:0] != 2'b00) begin
      q.push_back(c);
      m_trap = 1'b1;
    end else begin
      c.pc_write = 1'b1;
      c.next_pc  = tgt;
      q.push_back(c);
      m_pc = tgt;
    end
  endfunction

  function automatic void do_reset(int n, logic skip_first);
    cyc_t c;
    if (skip_first) begin
      c = base(); c.rst = 1'b0; c.chk = 1'b0; q.push_back(c);
    end
    m_pc = RV; m_ir = '0; m_trap = 1'b0; m_in_halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = base(); c.rst = 1'b0; q.push_back(c);
    end
    c = base(); q.push_back(c);
  endfunction

  function automatic logic legal(logic [6:0] o);
    return o inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
  endfunction

  // Expand one instruction into its cycle-by-cycle expected trace.
  function automatic void run_op(op_t o);
    cyc_t c;
    logic [6:0] opc;
    logic [31:0] tgt;
    logic st;
    int h;
    cur = o; h = o.halt; opc = o.word[6:0]; st = (opc == 7'h23);
    if (!m_in_halt && h > 0) begin
      c = base(); c.halt_req = 1'b1; q.push_back(c);
      m_in_halt = 1'b1; h--;
    end
    if (m_in_halt) begin
      for (int i = 0; i < h; i++) begin
        c = base(); c.halt_req = 1'b1; c.halted = 1'b1; q.push_back(c);
      end
      c = base(); c.halted = 1'b1; q.push_back(c);
      m_in_halt = 1'b0;
    end
    for (int i = 0; i < o.iwait; i++) begin
      c = base(); c.imem_req = 1'b1; q.push_back(c);
    end
    c = base(); c.imem_req = 1'b1; c.imem_ready = 1'b1; q.push_back(c);
    m_ir = o.word;
    c = base(); q.push_back(c);
    if (!legal(opc)) begin
      m_trap = 1'b1;
      return;
    end
    c = base();
    if (opc == 7'h63) begin
      commit(c, o.taken ? m_pc + o.imm : m_pc + 32'd4);
      return;
    end
    if (opc == 7'h0f || (opc == 7'h73 && o.word[14:12] == 3'b000)) begin
      commit(c, m_pc + 32'd4);
      if (opc == 7'h73 && !m_trap) m_in_halt = 1'b1;
      return;
    end
    q.push_back(c);
    if (opc == 7'h03 || st) begin
      for (int i = 0; i < o.dwait; i++) begin
        c = base(); c.dmem_req = 1'b1; c.dmem_we = st; q.push_back(c);
      end
      if (o.abort) begin
        c = base(); c.rst = 1'b0; c.dmem_req = 1'b1; c.dmem_we = st; q.push_back(c);
        do_reset(1, 1'b0);
        return;
      end
      c = base(); c.dmem_req = 1'b1; c.dmem_we = st; c.dmem_ready = 1'b1;
      if (st) begin
        commit(c, m_pc + 32'd4);
        return;
      end
      q.push_back(c);
    end
    c = base(); c.rf_we = 1'b1;
    if (opc == 7'h6f)      tgt = m_pc + o.imm;
    else if (opc == 7'h67) tgt = {o.alu[31:1], 1'b0};
    else                   tgt = m_pc + 32'd4;
    commit(c, tgt);
  endfunction

  function automatic void trap_tail(int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base(); q.push_back(c);
    end
  endfunction

  function automatic op_t mk(input logic [31:0] word, input logic [31:0] im, input logic [31:0] alu,
                             input logic tk, input int iw, input int dw, input int hl,
                             input logic ab, input int tg);
    op_t o;
    o.word = word; o.imm = im; o.alu = alu; o.taken = tk;
    o.iwait = iw; o.dwait = dw; o.halt = hl; o.abort = ab; o.tag = tg;
    return o;
  endfunction

  function automatic void check1(string name, int k, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, k, act, exp);
    end
  endfunction

  function automatic void check32(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, k, act, exp);
    end
  endfunction

  initial begin
    cyc_t c;
    rst = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    instr = '0; imm = '0; alu_result = '0;

    lit_npc[1]  = 32'h0100_0004; lit_pw[1]  = 1'b1;
    lit_npc[2]  = 32'h0100_0010; lit_pw[2]  = 1'b1;
    lit_npc[3]  = 32'h0100_0004; lit_pw[3]  = 1'b1;
    lit_npc[4]  = 32'h0100_0008; lit_pw[4]  = 1'b1;
    lit_npc[5]  = 32'h0200_0004; lit_pw[5]  = 1'b1;
    lit_npc[6]  = 32'h0100_0000; lit_pw[6]  = 1'b0;
    lit_npc[7]  = 32'h0100_0004; lit_pw[7]  = 1'b1;
    lit_npc[8]  = 32'h0000_0000; lit_pw[8]  = 1'b1;
    lit_npc[9]  = 32'h0200_0008; lit_pw[9]  = 1'b1;
    lit_npc[10] = 32'h0200_0010; lit_pw[10] = 1'b0;

    cur = mk(32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0);
    m_pc = RV; m_ir = '0; m_trap = 1'b0; m_in_halt = 1'b0;

    // ADDI straight out of reset
    do_reset(1, 1'b1);
    run_op(mk(32'h0050_0093, 32'h5, 32'h0, 1'b0, 0, 0, 0, 1'b0, 1));
    // BEQ taken
    do_reset(1, 1'b1);
    run_op(mk(32'h0000_0863, 32'h10, 32'h0, 1'b1, 0, 0, 0, 1'b0, 2));
    // BEQ not taken, then a mix of classes, waits, ECALL/halt and a misaligned JALR
    do_reset(1, 1'b1);
    run_op(mk(32'h0000_0863, 32'h10, 32'h0, 1'b0, 0, 0, 0, 1'b0, 3));
    run_op(mk(32'h0000_a103, 32'h0, 32'h0000_2000, 1'b0, 1, 3, 0, 1'b0, 4));
    run_op(mk(32'h0020_a023, 32'h4, 32'h0000_2004, 1'b0, 0, 1, 0, 1'b0, 0));
    run_op(mk(32'h1234_51b7, 32'h1234_5000, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    run_op(mk(32'h0000_0197, 32'h0, 32'h0, 1'b1, 2, 0, 0, 1'b0, 0));
    run_op(mk(32'h0020_81b3, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    run_op(mk(32'h0ff0_000f, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    run_op(mk(32'h1000_00ef, 32'h100, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    run_op(mk(32'h0001_00e7, 32'h0, 32'h0200_0005, 1'b0, 0, 0, 0, 1'b0, 5));
    run_op(mk(32'h0000_0073, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 9));
    run_op(mk(32'h0050_0093, 32'h5, 32'h0, 1'b0, 0, 0, 2, 1'b0, 0));
    run_op(mk(32'h0050_0093, 32'h5, 32'h0, 1'b0, 0, 0, 3, 1'b0, 0));
    run_op(mk(32'h0001_00e7, 32'h0, 32'h0200_0007, 1'b0, 0, 0, 0, 1'b0, 10));
    trap_tail(4);
    // JAL to a misaligned target
    do_reset(1, 1'b1);
    run_op(mk(32'h0020_00ef, 32'h2, 32'h0, 1'b0, 0, 0, 0, 1'b0, 6));
    trap_tail(3);
    // Illegal opcode
    do_reset(1, 1'b1);
    run_op(mk(32'h0000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    trap_tail(3);
    // Reset during a load, then PC wrap at the top of memory
    do_reset(1, 1'b1);
    run_op(mk(32'h0000_a103, 32'h0, 32'h0000_3000, 1'b0, 0, 2, 0, 1'b1, 0));
    run_op(mk(32'h0050_0093, 32'h5, 32'h0, 1'b0, 0, 0, 0, 1'b0, 7));
    run_op(mk(32'h1000_00ef, 32'hFEFF_FFF8, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));
    run_op(mk(32'h0ff0_000f, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0, 8));
    run_op(mk(32'h0050_0093, 32'h5, 32'h0, 1'b0, 0, 0, 0, 1'b0, 0));

    for (int k = 0; k < q.size(); k++) begin
      c = q[k];
      @(posedge clk);
      #1;
      rst = c.rst; halt_req = c.halt_req; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
      branch_taken = c.taken; instr = c.instr; imm = c.imm; alu_result = c.alu;
      @(negedge clk);
      if (c.chk) begin
        check1("imem_req", k, imem_req, c.imem_req);
        check1("dmem_req", k, dmem_req, c.dmem_req);
        check1("dmem_we", k, dmem_we, c.dmem_we);
        check1("rf_we", k, rf_we, c.rf_we);
        check1("pc_write", k, pc_write, c.pc_write);
        check1("halted", k, halted, c.halted);
        check1("trap", k, trap, c.trap);
        check32("pc", k, pc, c.pc);
        check32("next_pc", k, next_pc, c.next_pc);
        check32("ir", k, ir, c.ir);
      end
      if (c.tag > 0) begin
        check32("lit_model_next_pc", k, c.next_pc, lit_npc[c.tag]);
        check1("lit_model_pc_write", k, c.pc_write, lit_pw[c.tag]);
        check32("lit_dut_next_pc", k, next_pc, lit_npc[c.tag]);
        check1("lit_dut_pc_write", k, pc_write, lit_pw[c.tag]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
